// File: rtl/mux_n1_scan_if.sv
// Channel data, select and control in; registered selection out.
// The master drives the channel inputs and the slave is the multiplexer.
interface mux_n1_scan_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic [N*WIDTH-1:0] d;
    logic [SELW-1:0]    s;
    logic               mode;
    logic               hold;
    logic [WIDTH-1:0]   y;
    logic [SELW-1:0]    y_sel;
    logic               y_valid;
    logic               wrap;

    modport master (
        output d, s, mode, hold,
        input  y, y_sel, y_valid, wrap
    );

    modport slave (
        input  d, s, mode, hold,
        output y, y_sel, y_valid, wrap
    );
endinterface

// File: rtl/mux_n1_scan.sv
// Registered N-to-1 multiplexer with manual select and round-robin auto-scan.
// Auto-scan holds each channel for DWELL cycles and pulses wrap on the last cycle of channel N-1.
module mux_n1_scan #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned DWELL = 2
) (
    input logic            clk,
    input logic            rst,
    mux_n1_scan_if.slave   bus
);
    localparam int unsigned SELW = $clog2(N);
    localparam int unsigned DW   = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]    dwell_q, dwell_d;

    always_comb begin
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;

        if (!bus.hold) begin
            if (!bus.mode) begin
                // Out-of-range selects (non power-of-2 N) match no channel and yield 0.
                y_d     = '0;
                valid_d = 1'b0;
                sel_d   = bus.s;
                ptr_d   = '0;
                dwell_d = '0;
                for (int i = 0; i < N; i++) begin
                    if (bus.s == SELW'(i)) begin
                        y_d     = bus.d[i*WIDTH +: WIDTH];
                        valid_d = 1'b1;
                    end
                end
            end else begin
                y_d     = '0;
                sel_d   = ptr_q;
                valid_d = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (ptr_q == SELW'(i)) begin
                        y_d = bus.d[i*WIDTH +: WIDTH];
                    end
                end
                if (dwell_q == DW'(DWELL - 1)) begin
                    dwell_d = '0;
                    if (ptr_q == SELW'(N - 1)) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            ptr_q   <= '0;
            dwell_q <= '0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_sel   = sel_q;
    assign bus.y_valid = valid_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_n1_scan.sv
// Random and directed stimulus on three configurations of mux_n1_scan,
// checked each cycle against a cycle-count model of the scan schedule.
module tb_mux_n1_scan;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_n1_scan_if #(.WIDTH(8), .N(4)) ifa ();
    mux_n1_scan_if #(.WIDTH(8), .N(3)) ifb ();
    mux_n1_scan_if #(.WIDTH(8), .N(5)) ifc ();

    mux_n1_scan #(.WIDTH(8), .N(4), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux_n1_scan #(.WIDTH(8), .N(3), .DWELL(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mux_n1_scan #(.WIDTH(8), .N(5), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        int         k;   // cycles spent in the current auto-scan run, modulo N*DWELL
        logic [7:0] y;
        int         sel;
        logic       v;
        logic       w;
    } mdl_t;

    mdl_t ma, mb, mc;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input int n, input int dw, input logic [63:0] dd,
                                  input int s, input bit mode, input bit hold, input bit r);
        mdl_t o = m;
        int   p;
        if (r) begin
            o.k = 0; o.y = 8'h00; o.sel = 0; o.v = 1'b0; o.w = 1'b0;
        end else if (hold) begin
            o.w = 1'b0;
        end else if (!mode) begin
            o.k   = 0;
            o.sel = s;
            o.w   = 1'b0;
            o.v   = (s < n);
            o.y   = (s < n) ? dd[s*8 +: 8] : 8'h00;
        end else begin
            p     = (m.k / dw) % n;
            o.y   = dd[p*8 +: 8];
            o.sel = p;
            o.v   = 1'b1;
            o.w   = (m.k == n*dw - 1);
            o.k   = (m.k + 1) % (n*dw);
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        ma = step(ma, 4, 2, 64'(ifa.d), int'(ifa.s), ifa.mode, ifa.hold, rst);
        mb = step(mb, 3, 3, 64'(ifb.d), int'(ifb.s), ifb.mode, ifb.hold, rst);
        mc = step(mc, 5, 1, 64'(ifc.d), int'(ifc.s), ifc.mode, ifc.hold, rst);
        #1;
        check_eq("a.y", 32'(ifa.y), 32'(ma.y));
        check_eq("a.y_sel", 32'(ifa.y_sel), 32'(ma.sel));
        check_eq("a.y_valid", 32'(ifa.y_valid), 32'(ma.v));
        check_eq("a.wrap", 32'(ifa.wrap), 32'(ma.w));
        check_eq("b.y", 32'(ifb.y), 32'(mb.y));
        check_eq("b.y_sel", 32'(ifb.y_sel), 32'(mb.sel));
        check_eq("b.y_valid", 32'(ifb.y_valid), 32'(mb.v));
        check_eq("b.wrap", 32'(ifb.wrap), 32'(mb.w));
        check_eq("c.y", 32'(ifc.y), 32'(mc.y));
        check_eq("c.y_sel", 32'(ifc.y_sel), 32'(mc.sel));
        check_eq("c.y_valid", 32'(ifc.y_valid), 32'(mc.v));
        check_eq("c.wrap", 32'(ifc.wrap), 32'(mc.w));
    endtask

    initial begin
        ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
        rst = 1'b1;
        ifa.d = 32'h44332211; ifa.s = '0; ifa.mode = 1'b1; ifa.hold = 1'b0;
        ifb.d = 24'h332211;   ifb.s = '0; ifb.mode = 1'b0; ifb.hold = 1'b0;
        ifc.d = 40'h5544332211; ifc.s = '0; ifc.mode = 1'b1; ifc.hold = 1'b0;

        // Reset with auto-scan requested.
        tick(); tick();
        check_eq("a.rst_y", 32'(ifa.y), 32'h0);
        check_eq("a.rst_valid", 32'(ifa.y_valid), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("a.first_y", 32'(ifa.y), 32'h11);
        check_eq("c.first_y", 32'(ifc.y), 32'h11);

        // Manual stepping, then live data change on a selected channel.
        ifa.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.s = 2'(i);
            tick();
        end
        check_eq("a.man3", 32'(ifa.y), 32'h44);
        ifa.d[23:16] = 8'hA5; ifa.s = 2'd2;
        tick();
        check_eq("a.live", 32'(ifa.y), 32'hA5);

        // Invalid select on N=3, then a legal one.
        ifb.s = 2'd3;
        tick();
        check_eq("b.inv_y", 32'(ifb.y), 32'h0);
        check_eq("b.inv_sel", 32'(ifb.y_sel), 32'h3);
        ifb.s = 2'd1;
        tick();
        check_eq("b.leg_y", 32'(ifb.y), 32'h22);

        // Auto-scan for two full periods, with a hold inside the second.
        ifa.d = 32'h44332211; ifa.mode = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_eq("a.wrap_end", 32'(ifa.wrap), 32'h1);
        tick(); tick(); tick();
        check_eq("a.pre_hold", 32'(ifa.y), 32'h22);
        ifa.hold = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("a.held_y", 32'(ifa.y), 32'h22);
        ifa.hold = 1'b0;
        tick(); tick();
        check_eq("a.after_hold", 32'(ifa.y), 32'h33);
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        check_eq("a.rst_restart", 32'(ifa.y), 32'h11);

        // DWELL=1 mode toggle mid-scan restarts at channel 0.
        tick(); tick();
        ifc.mode = 1'b0; tick();
        ifc.mode = 1'b1; tick();
        check_eq("c.restart", 32'(ifc.y), 32'h11);

        // Random phase.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst      = ($urandom_range(63) == 0);
            ifa.hold = ($urandom_range(7) == 0);
            ifb.hold = ($urandom_range(7) == 0);
            ifc.hold = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) ifa.mode = ~ifa.mode;
            if ($urandom_range(15) == 0) ifb.mode = ~ifb.mode;
            if ($urandom_range(15) == 0) ifc.mode = ~ifc.mode;
            ifa.d = $urandom;
            ifb.d = 24'($urandom);
            ifc.d = {8'($urandom), 32'($urandom)};
            ifa.s = 2'($urandom_range(3));
            ifb.s = 2'($urandom_range(3));
            ifc.s = 3'($urandom_range(7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
